// File: rtl/reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_arbiter
//  Purpose  : Four-requester round-robin arbiter guarding one shared register.
//             Each granted request performs a single write of its data word,
//             acknowledged by a one-cycle pulse, and bumps a wrapping counter.
//  Revision : 1.0  initial release
// ============================================================================
module reg_arbiter #(
    parameter int N  = 8,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    req,
    input  logic [N-1:0]  d0,
    input  logic [N-1:0]  d1,
    input  logic [N-1:0]  d2,
    input  logic [N-1:0]  d3,
    output logic [3:0]    gnt,
    output logic [3:0]    ack,
    output logic [N-1:0]  q,
    output logic [1:0]    owner,
    output logic          busy,
    output logic [CW-1:0] wr_count
);

    // ------------------------------------------------------------------------
    // State encoding: one transaction always walks IDLE -> GRANT -> ACK.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t         r_state;
    logic [1:0]     r_ptr;      // round-robin start point for the next scan
    logic [1:0]     r_sel;      // requester that owns the current transaction
    logic [3:0]     r_gnt;
    logic [3:0]     r_ack;
    logic [N-1:0]   r_q;
    logic [1:0]     r_owner;
    logic           r_busy;
    logic [CW-1:0]  r_cnt;

    logic [1:0]     w_winner;
    logic           w_found;
    logic [1:0]     w_idx;
    logic [N-1:0]   w_dsel;

    // ------------------------------------------------------------------------
    // Round-robin scan: first set req bit starting at r_ptr and wrapping.
    // The 2-bit index wraps naturally, so ptr+k needs no explicit modulo.
    // ------------------------------------------------------------------------
    always_comb begin
        w_winner = r_ptr;
        w_found  = 1'b0;
        w_idx    = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + k[1:0];
            if (!w_found && req[w_idx]) begin
                w_winner = w_idx;
                w_found  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Data mux of the selected requester, sampled on the GRANT->ACK edge so a
    // requester may still update its word while it is being granted.
    // ------------------------------------------------------------------------
    always_comb begin
        w_dsel = d0;
        case (r_sel)
            2'd0:    w_dsel = d0;
            2'd1:    w_dsel = d1;
            2'd2:    w_dsel = d2;
            2'd3:    w_dsel = d3;
            default: w_dsel = d0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Transaction FSM with all outputs registered. Reset aborts any transaction
    // in flight without writing q or advancing the pointer.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd0;
            r_sel   <= 2'd0;
            r_gnt   <= 4'b0000;
            r_ack   <= 4'b0000;
            r_q     <= '0;
            r_owner <= 2'd0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack <= 4'b0000;
                    if (w_found) begin
                        r_state <= ST_GRANT;
                        r_sel   <= w_winner;
                        r_gnt   <= 4'b0001 << w_winner;
                        r_busy  <= 1'b1;
                    end else begin
                        r_gnt  <= 4'b0000;
                        r_busy <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    // Grant is never withdrawn: the write completes even if
                    // the requester dropped its request meanwhile.
                    r_state <= ST_ACK;
                    r_gnt   <= 4'b0000;
                    r_ack   <= 4'b0001 << r_sel;
                    r_q     <= w_dsel;
                    r_owner <= r_sel;
                    r_ptr   <= r_sel + 2'd1;
                    r_cnt   <= r_cnt + CW'(1);
                    r_busy  <= 1'b1;
                end
                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_ack   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 4'b0000;
                    r_ack   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------------
    assign gnt      = r_gnt;
    assign ack      = r_ack;
    assign q        = r_q;
    assign owner    = r_owner;
    assign busy     = r_busy;
    assign wr_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_arbiter
//  Purpose  : Directed self-checking bench for reg_arbiter with a
//             transaction-level reference model compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_arbiter;

    localparam int N  = 8;
    localparam int CW = 8;

    logic          clk;
    logic          reset;
    logic [3:0]    req;
    logic [N-1:0]  d0, d1, d2, d3;
    logic [3:0]    gnt;
    logic [3:0]    ack;
    logic [N-1:0]  q;
    logic [1:0]    owner;
    logic          busy;
    logic [CW-1:0] wr_count;

    int errors = 0;
    int checks = 0;

    reg_arbiter #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .gnt      (gnt),
        .ack      (ack),
        .q        (q),
        .owner    (owner),
        .busy     (busy),
        .wr_count (wr_count)
    );

    // 10-time-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a transaction is "remaining cycles" in flight
    // (2 = grant cycle, 1 = ack cycle, 0 = free). Winner is found by a plain
    // modular scan from the pointer.
    // ------------------------------------------------------------------------
    int            m_left;
    int            m_sel;
    int            m_ptr;
    logic [N-1:0]  m_q;
    int            m_owner;
    int            m_cnt;

    function automatic int rr_pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [N-1:0] pick_data(input int i);
        case (i)
            0: return d0;
            1: return d1;
            2: return d2;
            default: return d3;
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left  <= 0;
            m_sel   <= 0;
            m_ptr   <= 0;
            m_q     <= '0;
            m_owner <= 0;
            m_cnt   <= 0;
        end else if (m_left == 0) begin
            if (req != 4'b0000) begin
                m_sel  <= rr_pick(req, m_ptr);
                m_left <= 2;
            end
        end else if (m_left == 2) begin
            m_q     <= pick_data(m_sel);
            m_owner <= m_sel;
            m_ptr   <= (m_sel + 1) % 4;
            m_cnt   <= (m_cnt + 1) % (1 << CW);
            m_left  <= 1;
        end else begin
            m_left <= 0;
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare on the falling edge, away from the active edge.
    // ------------------------------------------------------------------------
    always @(negedge clk) begin
        chk("m_gnt",   {28'd0, gnt},  (m_left == 2) ? (32'd1 << m_sel) : 32'd0);
        chk("m_ack",   {28'd0, ack},  (m_left == 1) ? (32'd1 << m_sel) : 32'd0);
        chk("m_busy",  {31'd0, busy}, {31'd0, (m_left != 0)});
        chk("m_q",     {24'd0, q},    {24'd0, m_q});
        chk("m_owner", {30'd0, owner}, m_owner);
        chk("m_count", {24'd0, wr_count}, m_cnt);
        chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
        chk("ack_onehot0", {31'd0, $onehot0(ack)}, 32'd1);
        if (m_left != 1)
            chk("ack_outside_ack", {28'd0, ack}, 32'd0);
    end

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        d0 = '0; d1 = '0; d2 = '0; d3 = '0;
        step();
        // Reset values, literal
        chk("rst_q",     {24'd0, q}, 32'h0);
        chk("rst_busy",  {31'd0, busy}, 32'h0);
        chk("rst_count", {24'd0, wr_count}, 32'h0);
        step();
        reset = 1'b0;

        // Single request from requester 2
        req = 4'b0100; d2 = 8'h5A;
        step();
        chk("t1_gnt", {28'd0, gnt}, 32'h4);
        req = 4'b0000;
        step();
        chk("t1_q",     {24'd0, q}, 32'h5A);
        chk("t1_owner", {30'd0, owner}, 32'd2);
        chk("t1_ack",   {28'd0, ack}, 32'h4);
        chk("t1_count", {24'd0, wr_count}, 32'd1);
        step();
        chk("t1_busy",  {31'd0, busy}, 32'd0);

        // All four requesting continuously: rotation from ptr = 0
        do_reset();
        d0 = 8'h10; d1 = 8'h11; d2 = 8'h12; d3 = 8'h13;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_gnt", {28'd0, gnt}, 32'd1 << i);
            step();
            chk("t2_q",   {24'd0, q}, 32'h10 + i);
            chk("t2_ack", {28'd0, ack}, 32'd1 << i);
            step();
            chk("t2_idle_ack", {28'd0, ack}, 32'd0);
        end
        req = 4'b0000;
        chk("t2_count", {24'd0, wr_count}, 32'd4);
        step();

        // Request dropped in GRANT, data changed: write still completes
        req = 4'b0001; d0 = 8'h11;
        step();
        chk("t3_gnt", {28'd0, gnt}, 32'h1);
        req = 4'b0000; d0 = 8'h22;
        step();
        chk("t3_q",   {24'd0, q}, 32'h22);
        chk("t3_ack", {28'd0, ack}, 32'h1);
        step();

        // Asynchronous reset in the middle of a GRANT cycle
        req = 4'b0010; d1 = 8'hFF;
        step();
        chk("t4_gnt", {28'd0, gnt}, 32'h2);
        req = 4'b0000;
        #2 reset = 1'b1;
        #1;
        chk("t4_q",     {24'd0, q}, 32'h0);
        chk("t4_gnt0",  {28'd0, gnt}, 32'h0);
        chk("t4_ack0",  {28'd0, ack}, 32'h0);
        chk("t4_owner", {30'd0, owner}, 32'h0);
        chk("t4_count", {24'd0, wr_count}, 32'h0);
        chk("t4_busy",  {31'd0, busy}, 32'h0);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t4_no_ack", {28'd0, ack}, 32'h0);
        end

        // Counter wrap: 255 writes from requester 0, then one from requester 1
        do_reset();
        req = 4'b0001;
        for (int i = 0; i < 255; i++) begin
            d0 = 8'(i);
            step();
            step();
            step();
        end
        chk("t5_count255", {24'd0, wr_count}, 32'd255);
        req = 4'b0010; d1 = 8'hC3;
        step();
        chk("t5_gnt", {28'd0, gnt}, 32'h2);
        req = 4'b0000;
        step();
        chk("t5_count0", {24'd0, wr_count}, 32'd0);
        chk("t5_q",      {24'd0, q}, 32'hC3);
        chk("t5_owner",  {30'd0, owner}, 32'd1);
        chk("t5_ack",    {28'd0, ack}, 32'h2);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
